// File: rtl/pin_filter_chan.sv
// Single-pin glitch filter, edge detector and sticky write-1-to-clear interrupt bit.
// Input d_i must already be synchronized to clk_i.
module pin_filter_chan #(
   parameter int unsigned FilterCycles = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   input  logic filter_en_i,
   input  logic rise_en_i,
   input  logic fall_en_i,
   input  logic clear_i,
   output logic q_o,
   output logic intr_o
);

   localparam int unsigned     CntW   = $clog2(FilterCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            data_q;
   logic            intr_q, intr_d;
   logic            rise, fall;

   // Counter only advances while the input disagrees with the accepted value; any
   // agreement or a disabled filter drops the partial count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (!filter_en_i) begin
         stable_d = d_i;
      end else if (d_i != stable_q) begin
         if (cnt_q == CntMax) begin
            stable_d = d_i;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   assign rise = stable_q & ~data_q;
   assign fall = ~stable_q & data_q;

   // A new event on the same edge as a clear wins, so no edge is ever lost.
   assign intr_d = (intr_q & ~clear_i) | (rise & rise_en_i) | (fall & fall_en_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         data_q   <= 1'b0;
         intr_q   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         data_q   <= stable_q;
         intr_q   <= intr_d;
      end
   end

   assign q_o    = stable_q;
   assign intr_o = intr_q;

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer bringing a multi-bit asynchronous bus into the clk_i domain.
// Each bit is synchronized independently, so a multi-bit value may arrive skewed by one cycle.
module prim_flop_2sync #(
   parameter int unsigned      Width      = 16,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] sync1_q;
   logic [Width-1:0] sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= ResetValue;
         sync2_q <= ResetValue;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
      end
   end

   assign q_o = sync2_q;

endmodule

// File: rtl/pin_filter_sync.sv
// Receiver for asynchronous pins: 2-flop synchronizer, per-pin glitch filter,
// edge detection and sticky interrupt state with a combined interrupt output.
module pin_filter_sync #(
   parameter int unsigned Width        = 8,
   parameter int unsigned FilterCycles = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] pins_i,
   input  logic [Width-1:0] filter_en_i,
   input  logic [Width-1:0] rise_en_i,
   input  logic [Width-1:0] fall_en_i,
   input  logic [Width-1:0] intr_clear_i,
   output logic [Width-1:0] data_o,
   output logic [Width-1:0] intr_state_o,
   output logic             intr_o
);

   logic [Width-1:0] sync2;

   prim_flop_2sync #(
      .Width      (Width),
      .ResetValue ('0)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (pins_i),
      .q_o    (sync2)
   );

   for (genvar i = 0; i < Width; i++) begin : g_chan
      pin_filter_chan #(
         .FilterCycles (FilterCycles)
      ) u_chan (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .d_i         (sync2[i]),
         .filter_en_i (filter_en_i[i]),
         .rise_en_i   (rise_en_i[i]),
         .fall_en_i   (fall_en_i[i]),
         .clear_i     (intr_clear_i[i]),
         .q_o         (data_o[i]),
         .intr_o      (intr_state_o[i])
      );
   end

   assign intr_o = |intr_state_o;

endmodule

// File: tb/tb_pin_filter_sync.sv
// Randomized and directed bench for pin_filter_sync with a queue-based scoreboard.
module tb_pin_filter_sync;

   localparam int W  = 8;
   localparam int FC = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] pins, fen, ren, falen, clr;
   logic [W-1:0] data, st;
   logic         irq;

   always #5 clk = ~clk;

   pin_filter_sync #(
      .Width        (W),
      .FilterCycles (FC)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .pins_i       (pins),
      .filter_en_i  (fen),
      .rise_en_i    (ren),
      .fall_en_i    (falen),
      .intr_clear_i (clr),
      .data_o       (data),
      .intr_state_o (st),
      .intr_o       (irq)
   );

   typedef struct packed {
      logic [W-1:0] data;
      logic [W-1:0] st;
      logic         irq;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: two-deep sample delay, per-pin run-length of disagreement,
   // previous accepted value for edges, sticky event set.
   logic [W-1:0] m_s1, m_s2, m_stab, m_prev, m_st;
   int           m_run[W];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_prev = '0; m_st = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   task automatic model_step();
      logic [W-1:0] n_stab, rise, fall;
      if (!rst_n) begin
         model_reset();
      end else begin
         rise = m_stab & ~m_prev;
         fall = ~m_stab & m_prev;
         n_stab = m_stab;
         for (int i = 0; i < W; i++) begin
            if (!fen[i]) begin
               n_stab[i] = m_s2[i];
               m_run[i] = 0;
            end else if (m_s2[i] == m_stab[i]) begin
               m_run[i] = 0;
            end else if (m_run[i] + 1 >= FC) begin
               n_stab[i] = m_s2[i];
               m_run[i] = 0;
            end else begin
               m_run[i] = m_run[i] + 1;
            end
         end
         m_st   = (m_st & ~clr) | (rise & ren) | (fall & falen);
         m_prev = m_stab;
         m_stab = n_stab;
         m_s2   = m_s1;
         m_s1   = pins;
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.data = m_stab;
      e.st   = m_st;
      e.irq  = |m_st;
      return e;
   endfunction

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_o", data, e.data);
            check("intr_state_o", st, e.st);
            check("intr_o", W'(irq), W'(e.irq));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      exp_q.push_back(model_out());
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic pulse_clear(input logic [W-1:0] m);
      clr = m;
      cyc();
      clr = '0;
   endtask

   initial begin : driver
      rst_n = 1'b0; pins = '0; fen = '0; ren = 8'h01; falen = '0; clr = '0;
      model_reset();
      run(2);
      rst_n = 1'b1;

      // Propagation: change before edge 5 after release, filters off
      run(4);
      pins = 8'h01;
      run(6);

      // Glitch rejection on pin 0
      fen = 8'h01;
      pins = 8'h00;
      run(20);
      pulse_clear(8'h01);
      pins = 8'h01; run(15);
      pins = 8'h00; run(20);
      pins = 8'h01; run(16);
      pins = 8'h00; run(25);

      // Clear colliding with a falling event on pin 1
      fen = '0; ren = '0; falen = 8'h02;
      pulse_clear(8'hFF);
      pins = 8'h02; run(5);
      pins = 8'h00; run(3);
      pulse_clear(8'h02);
      run(3);
      pulse_clear(8'h02);
      run(2);

      // Filter enable toggled mid-count on pin 3
      falen = '0; ren = 8'h08; fen = 8'h08;
      pins = 8'h08; run(12);
      fen = 8'h00; cyc();
      fen = 8'h08;
      pins = 8'h00; run(12);
      fen = 8'h00; cyc();
      fen = 8'h08; run(20);

      // Fill interrupt state, start counts, then async reset between edges
      fen = '0; ren = 8'hFF; falen = 8'hFF;
      pulse_clear(8'hFF);
      pins = 8'h00; run(5);
      pins = 8'hFF; run(5);
      fen = 8'hFF; pins = 8'h00; run(6);
      #1;
      rst_n = 1'b0;
      model_reset();
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(model_out());

      // Release reset with pins held high
      pins = 8'hFF; fen = '0; ren = 8'hFF; falen = '0;
      run(2);
      rst_n = 1'b1;
      run(6);

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         if (c % 60 == 0) begin
            fen   = W'($urandom);
            ren   = W'($urandom);
            falen = W'($urandom);
         end
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 23) == 0) pins[b] = ~pins[b];
         clr = ($urandom_range(0, 9) == 0) ? W'($urandom) : '0;
         cyc();
      end
      clr = '0;

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d pending, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
